// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared parameters and read-tag types for the BRAM arbiter
// Purpose: geometry of the shared 32K x 8 BRAM, its read latency, and the tag
//          carried alongside each in-flight read.
// Ports:   none (package)
package bram_arb_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    typedef logic owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - read tag shift register tracking BRAM read latency
// Purpose: (RD_LAT+1)-stage shift register of rd_tag_t. A tag enters at the
//          grant edge and leaves as the delivery strobe when bram_dout holds
//          the matching read data.
// Ports:   i_clk, i_rst    clock, synchronous active-high clear
//          i_tag           tag of the read granted this cycle (valid=0 if none)
//          o_deliver       last stage holds a live read
//          o_owner         master that issued that read
module rd_tag_pipe
    import bram_arb_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  rd_tag_t i_tag,
    output logic    o_deliver,
    output owner_t  o_owner
);
    rd_tag_t r_pipe [RD_LAT+1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_deliver = r_pipe[RD_LAT].valid;
    assign o_owner   = r_pipe[RD_LAT].owner;
endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-master round-robin arbiter and sequencer for the shared BRAM
// Purpose: grants one of two masters per cycle, drives registered BRAM pins,
//          stalls a read that directly follows a write to the same address,
//          and routes each read result back to the master that issued it.
// Ports:   i_clk, i_rst                       clock, synchronous active-high reset
//          i_mN_req/we/addr/wdata             request from master N (held until granted)
//          o_mN_gnt                           combinational grant, transfer at this edge
//          o_mN_rvalid, o_mN_rdata            one-cycle read response, data held
//          o_bram_en/ren/wen/addr/din         registered BRAM controls
//          i_bram_dout                        BRAM read data
module bram_arbiter
    import bram_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_bram_en,
    output logic              o_bram_ren,
    output logic              o_bram_wen,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_din,
    input  logic [DATA_W-1:0] i_bram_dout
);
    owner_t              r_last_grant;
    logic                r_bram_en, r_bram_ren, r_bram_wen;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [DATA_W-1:0]   r_bram_din;
    logic                r_m0_rvalid, r_m1_rvalid;
    logic [DATA_W-1:0]   r_m0_rdata, r_m1_rdata;

    owner_t              w_winner;
    logic                w_any_req, w_win_we, w_hazard, w_grant;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_deliver;
    owner_t              w_dlv_owner;
    rd_tag_t             w_tag;

    // On a tie the master not granted last time wins; otherwise the lone requester.
    always_comb begin
        w_any_req = i_m0_req | i_m1_req;
        if (i_m0_req && i_m1_req) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = i_m1_req;
        end
        w_win_we    = w_winner ? i_m1_we    : i_m0_we;
        w_win_addr  = w_winner ? i_m1_addr  : i_m0_addr;
        w_win_wdata = w_winner ? i_m1_wdata : i_m0_wdata;
    end

    // The issue registers still describe last cycle's grant, so a registered
    // write to the same address means the BRAM has not yet committed it.
    assign w_hazard = w_any_req && !w_win_we && r_bram_en && r_bram_wen
                      && (w_win_addr == r_bram_addr);
    assign w_grant  = w_any_req && !w_hazard && !i_rst;

    assign o_m0_gnt = w_grant && (w_winner == 1'b0);
    assign o_m1_gnt = w_grant && (w_winner == 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_bram_en    <= 1'b0;
            r_bram_ren   <= 1'b0;
            r_bram_wen   <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
            r_bram_en    <= 1'b1;
            r_bram_ren   <= ~w_win_we;
            r_bram_wen   <= w_win_we;
            r_bram_addr  <= w_win_addr;
            r_bram_din   <= w_win_wdata;
        end else begin
            r_bram_en    <= 1'b0;
            r_bram_ren   <= 1'b0;
            r_bram_wen   <= 1'b0;
        end
    end

    assign w_tag.valid = w_grant && !w_win_we;
    assign w_tag.owner = w_winner;

    rd_tag_pipe u_rd_tag_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_tag     (w_tag),
        .o_deliver (w_deliver),
        .o_owner   (w_dlv_owner)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_deliver && (w_dlv_owner == 1'b0);
            r_m1_rvalid <= w_deliver && (w_dlv_owner == 1'b1);
            if (w_deliver && (w_dlv_owner == 1'b0)) begin
                r_m0_rdata <= i_bram_dout;
            end
            if (w_deliver && (w_dlv_owner == 1'b1)) begin
                r_m1_rdata <= i_bram_dout;
            end
        end
    end

    assign o_bram_en   = r_bram_en;
    assign o_bram_ren  = r_bram_ren;
    assign o_bram_wen  = r_bram_wen;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_din  = r_bram_din;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
endmodule
